// File: rtl/lsu_align_if.sv
// Purpose: core-side request/response and memory-side bus bundle for lsu_align.
// Latency: wires only, no state.
// Backpressure: none here; stalls are carried by o_busy and i_mem_ack.
interface lsu_align_if;
   // Core request
   logic        i_req;
   logic        i_we;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;

   // Core status / load result
   logic        o_busy;
   logic        o_done;
   logic        o_err_access;
   logic        o_err_timeout;
   logic [31:0] o_ld_data;
   logic [3:0]  o_ld_mask;
   logic        o_ld_unsigned;

   // Memory side
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   // The aligner itself: consumes core requests and memory responses
   modport slave (
      input  i_req, i_we, i_funct3, i_addr, i_wdata,
      input  i_mem_ack, i_mem_rdata,
      output o_busy, o_done, o_err_access, o_err_timeout,
      output o_ld_data, o_ld_mask, o_ld_unsigned,
      output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
   );

   // The environment: drives core requests and plays the memory
   modport master (
      output i_req, i_we, i_funct3, i_addr, i_wdata,
      output i_mem_ack, i_mem_rdata,
      input  o_busy, o_done, o_err_access, o_err_timeout,
      input  o_ld_data, o_ld_mask, o_ld_unsigned,
      input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
   );
endinterface

// File: rtl/lsu_align.sv
// Purpose: RISC-V load/store aligner: size/alignment check, byte enables, store lane replication, load shift.
// Latency: request at N, o_mem_req from N+1, ack at N+k, o_done at N+k+1; illegal request done at N+1.
// Backpressure: o_busy stalls the core in ACCESS/RESP; memory stalls by withholding i_mem_ack up to TIMEOUT cycles.
module lsu_align #(
   parameter int unsigned TIMEOUT = 16
) (
   input logic        i_clk,
   input logic        i_reset,
   lsu_align_if.slave bus
);

   localparam logic [7:0] TMO = TIMEOUT[7:0];

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;

   // Captured request attributes needed after the request is gone
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  alo_q;

   // Registered outputs
   logic        busy_q;
   logic        done_q;
   logic        err_acc_q;
   logic        err_tmo_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [3:0]  mem_be_q;
   logic [31:0] ld_data_q;
   logic [3:0]  ld_mask_q;
   logic        ld_uns_q;

   // Request decode (valid only while IDLE samples i_req)
   logic        req_illegal;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;

   // Load completion values derived from the captured request
   logic [31:0] ld_data_d;
   logic [3:0]  ld_mask_d;

   // Decode size code and address into legality, byte enables and replicated store data
   always_comb begin
      req_illegal = 1'b0;
      req_be      = 4'b0000;
      req_wdata   = bus.i_wdata;
      case (bus.i_funct3[1:0])
         2'b00: begin
            req_be    = 4'b0001 << bus.i_addr[1:0];
            req_wdata = {4{bus.i_wdata[7:0]}};
         end
         2'b01: begin
            req_be      = 4'b0011 << {bus.i_addr[1], 1'b0};
            req_wdata   = {2{bus.i_wdata[15:0]}};
            req_illegal = bus.i_addr[0];
         end
         2'b10: begin
            req_be      = 4'b1111;
            req_illegal = (bus.i_addr[1:0] != 2'b00);
         end
         default: begin
            req_illegal = 1'b1;
         end
      endcase
      // 110 has no unsigned-word meaning on RV32; unsigned codes have no store form
      if (bus.i_funct3 == 3'b110) begin
         req_illegal = 1'b1;
      end
      if (bus.i_we && bus.i_funct3[2]) begin
         req_illegal = 1'b1;
      end
   end

   // Shift the returned word so the addressed byte lands in [7:0], and size the mask
   always_comb begin
      ld_data_d = bus.i_mem_rdata >> {alo_q, 3'b000};
      case (f3_q[1:0])
         2'b00:   ld_mask_d = 4'b0001;
         2'b01:   ld_mask_d = 4'b0011;
         2'b10:   ld_mask_d = 4'b1111;
         default: ld_mask_d = 4'b0000;
      endcase
   end

   // Control FSM with all outputs registered
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         we_q        <= 1'b0;
         f3_q        <= 3'b000;
         alo_q       <= 2'b00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_acc_q   <= 1'b0;
         err_tmo_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_be_q    <= 4'b0000;
         ld_data_q   <= 32'd0;
         ld_mask_q   <= 4'b0000;
         ld_uns_q    <= 1'b0;
      end else begin
         // Completion flags are single-cycle pulses unless set below
         done_q    <= 1'b0;
         err_acc_q <= 1'b0;
         err_tmo_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.i_req) begin
                  we_q   <= bus.i_we;
                  f3_q   <= bus.i_funct3;
                  alo_q  <= bus.i_addr[1:0];
                  busy_q <= 1'b1;
                  if (req_illegal) begin
                     // Rejected without touching memory
                     state_q   <= RESP;
                     done_q    <= 1'b1;
                     err_acc_q <= 1'b1;
                     if (!bus.i_we) begin
                        ld_data_q <= 32'd0;
                        ld_mask_q <= 4'b0000;
                        ld_uns_q  <= 1'b0;
                     end
                  end else begin
                     state_q     <= ACCESS;
                     cnt_q       <= 8'd1;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= bus.i_we;
                     mem_addr_q  <= {bus.i_addr[31:2], 2'b00};
                     mem_wdata_q <= req_wdata;
                     mem_be_q    <= req_be;
                  end
               end
            end

            ACCESS: begin
               if (bus.i_mem_ack || (cnt_q == TMO)) begin
                  // Ack wins over a timeout landing in the same cycle
                  state_q     <= RESP;
                  cnt_q       <= 8'd0;
                  done_q      <= 1'b1;
                  err_tmo_q   <= !bus.i_mem_ack;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= 32'd0;
                  mem_wdata_q <= 32'd0;
                  mem_be_q    <= 4'b0000;
                  if (!we_q) begin
                     if (bus.i_mem_ack) begin
                        ld_data_q <= ld_data_d;
                        ld_mask_q <= ld_mask_d;
                        ld_uns_q  <= f3_q[2];
                     end else begin
                        ld_data_q <= 32'd0;
                        ld_mask_q <= 4'b0000;
                        ld_uns_q  <= 1'b0;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy        = busy_q;
   assign bus.o_done        = done_q;
   assign bus.o_err_access  = err_acc_q;
   assign bus.o_err_timeout = err_tmo_q;
   assign bus.o_mem_req     = mem_req_q;
   assign bus.o_mem_we      = mem_we_q;
   assign bus.o_mem_addr    = mem_addr_q;
   assign bus.o_mem_wdata   = mem_wdata_q;
   assign bus.o_mem_be      = mem_be_q;
   assign bus.o_ld_data     = ld_data_q;
   assign bus.o_ld_mask     = ld_mask_q;
   assign bus.o_ld_unsigned = ld_uns_q;

endmodule

// File: tb/tb_lsu_align.sv
// Purpose: directed bench for lsu_align with a completion scoreboard.
// Latency: checks o_done cycle against request cycle plus ack delay.
// Backpressure: bench plays the memory and withholds i_mem_ack to exercise stalls and timeout.
module tb_lsu_align;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_align_if bus();

   lsu_align #(.TIMEOUT(4)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   typedef struct {
      int          done_cyc;
      logic        ea;
      logic        et;
      logic [31:0] ld;
      logic [3:0]  mask;
      logic        uns;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      bus.i_req    = 1'b1;
      bus.i_we     = we;
      bus.i_funct3 = f3;
      bus.i_addr   = a;
      bus.i_wdata  = wd;
      tick();
      bus.i_req    = 1'b0;
   endtask

   task automatic push(input int dc, input logic ea, input logic et, input logic [31:0] ld,
                       input logic [3:0] mask, input logic uns);
      exp_t e;
      e.done_cyc = dc; e.ea = ea; e.et = et; e.ld = ld; e.mask = mask; e.uns = uns;
      sb.push_back(e);
   endtask

   // Wait (bounded) for o_done, then pop and compare the scoreboard entry
   task automatic wait_done(input string tag);
      exp_t e;
      int   n = 0;
      while (!bus.o_done && n < 12) begin
         tick();
         n++;
      end
      if (!bus.o_done || sb.size() == 0) begin
         check({tag, "-done"}, {31'd0, bus.o_done}, {31'd0, sb.size() != 0});
         sb.delete();
         return;
      end
      e = sb.pop_front();
      check({tag, "-cycle"},  cyc,                            e.done_cyc);
      check({tag, "-erracc"}, {31'd0, bus.o_err_access},      {31'd0, e.ea});
      check({tag, "-errtmo"}, {31'd0, bus.o_err_timeout},     {31'd0, e.et});
      check({tag, "-lddata"}, bus.o_ld_data,                  e.ld);
      check({tag, "-ldmask"}, {28'd0, bus.o_ld_mask},         {28'd0, e.mask});
      check({tag, "-lduns"},  {31'd0, bus.o_ld_unsigned},     {31'd0, e.uns});
      check({tag, "-busy"},   {31'd0, bus.o_busy},            32'd1);
      check({tag, "-memreq"}, {31'd0, bus.o_mem_req},         32'd0);
      tick();
      check({tag, "-pulse"},  {30'd0, bus.o_done, bus.o_busy}, 32'd0);
   endtask

   initial begin
      int n0;
      int hi;
      rst             = 1'b1;
      bus.i_req       = 1'b0;
      bus.i_we        = 1'b0;
      bus.i_funct3    = 3'b000;
      bus.i_addr      = 32'd0;
      bus.i_wdata     = 32'd0;
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = 32'd0;

      // Reset state
      tick(); tick(); tick();
      check("rst-ctl", {bus.o_busy, bus.o_done, bus.o_err_access, bus.o_err_timeout,
                        bus.o_mem_req, bus.o_mem_we, bus.o_ld_unsigned}, 32'd0);
      check("rst-memaddr", bus.o_mem_addr, 32'd0);
      check("rst-memwd",   bus.o_mem_wdata, 32'd0);
      check("rst-masks",   {24'd0, bus.o_mem_be, bus.o_ld_mask}, 32'd0);
      check("rst-lddata",  bus.o_ld_data, 32'd0);
      rst = 1'b0;
      tick();

      // Stray ack in IDLE is ignored
      bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hFFFF_FFFF;
      tick();
      bus.i_mem_ack = 1'b0;
      tick();
      check("idle-ack", {29'd0, bus.o_done, bus.o_busy, bus.o_mem_req}, 32'd0);
      check("idle-ack-ld", bus.o_ld_data, 32'd0);

      // LB 0x1003, ack at N+2
      n0 = cyc;
      issue(1'b0, 3'b000, 32'h0000_1003, 32'd0);
      check("lb-req",  {31'd0, bus.o_mem_req}, 32'd1);
      check("lb-be",   {28'd0, bus.o_mem_be}, 32'h8);
      check("lb-addr", bus.o_mem_addr, 32'h0000_1000);
      check("lb-we",   {31'd0, bus.o_mem_we}, 32'd0);
      tick();
      check("lb-req2", {31'd0, bus.o_mem_req}, 32'd1);
      bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h80AA_5511;
      push(n0 + 3, 1'b0, 1'b0, 32'h0000_0080, 4'b0001, 1'b0);
      tick();
      bus.i_mem_ack = 1'b0;
      wait_done("lb");

      // SH 0x2002, immediate ack; load outputs must hold
      n0 = cyc;
      issue(1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF);
      check("sh-addr", bus.o_mem_addr, 32'h0000_2000);
      check("sh-be",   {28'd0, bus.o_mem_be}, 32'hC);
      check("sh-wd",   bus.o_mem_wdata, 32'hBEEF_BEEF);
      check("sh-we",   {31'd0, bus.o_mem_we}, 32'd1);
      bus.i_mem_ack = 1'b1;
      push(n0 + 2, 1'b0, 1'b0, 32'h0000_0080, 4'b0001, 1'b0);
      tick();
      bus.i_mem_ack = 1'b0;
      wait_done("sh");

      // SB 0x8001, immediate ack
      n0 = cyc;
      issue(1'b1, 3'b000, 32'h0000_8001, 32'h0000_00A5);
      check("sb-be", {28'd0, bus.o_mem_be}, 32'h2);
      check("sb-wd", bus.o_mem_wdata, 32'hA5A5_A5A5);
      bus.i_mem_ack = 1'b1;
      push(n0 + 2, 1'b0, 1'b0, 32'h0000_0080, 4'b0001, 1'b0);
      tick();
      bus.i_mem_ack = 1'b0;
      wait_done("sb");

      // Illegal store with unsigned code: error, load outputs untouched
      n0 = cyc;
      push(n0 + 1, 1'b1, 1'b0, 32'h0000_0080, 4'b0001, 1'b0);
      issue(1'b1, 3'b100, 32'h0000_8000, 32'h0);
      check("sbu-noreq", {31'd0, bus.o_mem_req}, 32'd0);
      wait_done("sbu");

      // LW misaligned 0x3001: error at N+1, loads cleared
      n0 = cyc;
      push(n0 + 1, 1'b1, 1'b0, 32'd0, 4'b0000, 1'b0);
      issue(1'b0, 3'b010, 32'h0000_3001, 32'h0);
      check("lwmis-noreq", {31'd0, bus.o_mem_req}, 32'd0);
      wait_done("lwmis");

      // LW 0x5000, immediate ack
      n0 = cyc;
      issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
      check("lw-be", {28'd0, bus.o_mem_be}, 32'hF);
      bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hDEAD_BEEF;
      push(n0 + 2, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b1111, 1'b0);
      tick();
      bus.i_mem_ack = 1'b0;
      wait_done("lw");

      // LHU 0x4000 with no ack: exactly TIMEOUT request cycles, then timeout
      n0 = cyc;
      issue(1'b0, 3'b101, 32'h0000_4000, 32'h0);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         if (!bus.o_mem_req) break;
         hi++;
         tick();
      end
      check("tmo-reqcycles", hi, 32'd4);
      push(n0 + 5, 1'b0, 1'b1, 32'd0, 4'b0000, 1'b0);
      wait_done("tmo");

      // LBU 0x6002, ack on the 4th ACCESS cycle; i_req held high during ACCESS is ignored
      n0 = cyc;
      issue(1'b0, 3'b100, 32'h0000_6002, 32'h0);
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_7777; bus.i_funct3 = 3'b010;
      tick(); tick();
      check("late-addr", bus.o_mem_addr, 32'h0000_6000);
      check("late-be",   {28'd0, bus.o_mem_be}, 32'h4);
      tick();
      bus.i_req = 1'b0;
      bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h1122_3344;
      push(n0 + 5, 1'b0, 1'b0, 32'h0000_1122, 4'b0001, 1'b1);
      tick();
      bus.i_mem_ack = 1'b0;
      wait_done("ack4");

      // LH 0x7002, immediate ack
      n0 = cyc;
      issue(1'b0, 3'b001, 32'h0000_7002, 32'h0);
      check("lh-be", {28'd0, bus.o_mem_be}, 32'hC);
      bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hABCD_0000;
      push(n0 + 2, 1'b0, 1'b0, 32'h0000_ABCD, 4'b0011, 1'b0);
      tick();
      bus.i_mem_ack = 1'b0;
      wait_done("lh");

      // Illegal funct3 011 load
      n0 = cyc;
      push(n0 + 1, 1'b1, 1'b0, 32'd0, 4'b0000, 1'b0);
      issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
      wait_done("f3bad");

      // Reset during 2nd ACCESS cycle, late ack ignored
      issue(1'b0, 3'b010, 32'h0000_9000, 32'h0);
      tick();
      check("abort-req-before", {31'd0, bus.o_mem_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort-ctl", {bus.o_busy, bus.o_done, bus.o_err_access, bus.o_err_timeout,
                          bus.o_mem_req, bus.o_mem_we, bus.o_ld_unsigned}, 32'd0);
      check("abort-mem", bus.o_mem_addr | {28'd0, bus.o_mem_be}, 32'd0);
      bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h5555_5555;
      tick();
      bus.i_mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("abort-quiet", {30'd0, bus.o_done, bus.o_mem_req}, 32'd0);
         tick();
      end
      check("abort-ld", bus.o_ld_data, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_align.md
LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 The module SHALL have a parameter TIMEOUT, default 16, giving the maximum number of ACCESS cycles that wait for i_mem_ack (legal range 1..255).
REQ-002 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-high.
REQ-004 i_req  input  1  core access request, sampled only in IDLE.
REQ-005 i_we  input  1  1 = store, 0 = load.
REQ-006 i_funct3  input  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 i_addr  input  32  byte address.
REQ-008 i_wdata  input  32  store data, right-aligned.
REQ-009 o_busy  output  1  core stall; high in ACCESS and RESP.
REQ-010 o_done  output  1  one-cycle completion pulse.
REQ-011 o_err_access  output  1  misaligned address or illegal funct3; valid with o_done.
REQ-012 o_err_timeout  output  1  no memory ack within TIMEOUT cycles; valid with o_done.
REQ-013 o_mem_req, o_mem_we  output  1 each  memory request and write strobe.
REQ-014 o_mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-015 o_mem_wdata  output  32  lane-replicated store data.
REQ-016 o_mem_be  output  4  byte enables.
REQ-017 i_mem_ack  input  1  memory completion; i_mem_rdata  input  32  read word, valid with ack.
REQ-018 o_ld_data  output  32  load word shifted so the addressed byte is at bits [7:0].
REQ-019 o_ld_mask  output  4  load size for the downstream extender: 0001 B, 0011 H, 1111 W, 0000 on error.
REQ-020 o_ld_unsigned  output  1  funct3[2] of the completed load.

Function
REQ-021 FSM SHALL have three states: IDLE, ACCESS, RESP; RESP always returns to IDLE after one cycle.
REQ-022 IDLE with i_req=1 SHALL register we, funct3, addr, wdata; the next state is RESP if the request is illegal, else ACCESS.
REQ-023 Illegal: funct3 in {011,110,111}; store with funct3[2]=1; H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-024 Byte enables: B 0001<<addr[1:0]; H 0011<<{addr[1],1'b0}; W 1111; the same byte enables SHALL drive loads.
REQ-025 Store data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
REQ-026 In ACCESS, o_mem_req=1 with addr/we/wdata/be held stable until exit; all memory outputs are 0 outside ACCESS.
REQ-027 An ACCESS cycle counter SHALL start at 1 on the first ACCESS cycle; i_mem_ack=1 in any ACCESS cycle moves to RESP.
REQ-028 If i_mem_ack=0 in the cycle the counter equals TIMEOUT, the block SHALL move to RESP with o_err_timeout; an ack in that same cycle wins, with no error.
REQ-029 On a load ack, o_ld_data SHALL register i_mem_rdata >> (8*addr[1:0]), o_ld_mask is set from size, and o_ld_unsigned from funct3[2].
REQ-030 On any load error, o_ld_data SHALL be 0 and o_ld_mask 0000; stores never change the o_ld_* outputs.
REQ-031 o_ld_* SHALL hold until the next load completes.
REQ-032 o_done, o_err_access and o_err_timeout SHALL be high only in RESP, for exactly one cycle.
REQ-033 Latency: request at cycle N, o_mem_req from N+1, ack at N+k (k>=1), o_done at N+k+1; an illegal request gives o_done at N+1.
REQ-034 i_req outside IDLE and i_mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-035 While i_reset=1 at a clock edge: state IDLE, counter 0, every output 0 (including o_ld_data, o_ld_mask, o_ld_unsigned).
REQ-036 Reset during ACCESS or RESP SHALL abort the access: o_mem_req=0 from the next cycle, no o_done, and a late i_mem_ack is ignored.

Verification
REQ-037 LB addr 0x1003, rdata 0x80AA5511, ack after 2 cycles -> o_mem_be 1000, o_ld_data 0x00000080, mask 0001, unsigned 0, o_done at N+3.
REQ-038 SH addr 0x2002, wdata 0x1234BEEF, immediate ack -> o_mem_addr 0x2000, be 1100, wdata 0xBEEFBEEF, we 1, o_done at N+2.
REQ-039 LW addr 0x3001 -> no o_mem_req, o_done and o_err_access at N+1, o_ld_mask 0000, o_ld_data 0.
REQ-040 LHU addr 0x4000 with no ack, TIMEOUT=4 -> o_mem_req high exactly 4 cycles, then o_done with o_err_timeout, o_ld_data 0.
REQ-041 Ack on the 4th ACCESS cycle with TIMEOUT=4 -> normal completion, o_err_timeout 0.
REQ-042 i_reset asserted in the 2nd ACCESS cycle, then ack one cycle later -> o_mem_req 0 after the edge, no o_done, all outputs 0.
